// File: rtl/yacht_turn_ctrl_pkg.sv
// Shared types and constants for the Yacht Dice turn sequencer.
// Holds the FSM state encoding, category codes and the category legality check.
package yacht_turn_ctrl_pkg;

  localparam int NUM_CATS = 12;
  localparam int CAT_W    = 4;
  localparam int HOLD_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROLL   = 3'd1,
    S_DECIDE = 3'd2,
    S_COMMIT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [CAT_W-1:0] CAT_ACES       = 4'd0;
  localparam logic [CAT_W-1:0] CAT_SIXES      = 4'd5;
  localparam logic [CAT_W-1:0] CAT_CHOICE     = 4'd6;
  localparam logic [CAT_W-1:0] CAT_FOUR_KIND  = 4'd7;
  localparam logic [CAT_W-1:0] CAT_FULL_HOUSE = 4'd8;
  localparam logic [CAT_W-1:0] CAT_SM_STRAIGHT= 4'd9;
  localparam logic [CAT_W-1:0] CAT_LG_STRAIGHT= 4'd10;
  localparam logic [CAT_W-1:0] CAT_YACHT      = 4'd11;

  // Codes 12..15 index past the used mask, so widen it before indexing.
  function automatic logic cat_ok(input logic [CAT_W-1:0]    cat,
                                  input logic [NUM_CATS-1:0] used);
    logic [15:0] ext;
    ext = 16'(used);
    return (cat < 4'(NUM_CATS)) && !ext[cat];
  endfunction

endpackage

// File: rtl/yacht_turn_ctrl_if.sv
// Front-end / dice-generator signal bundle for the turn sequencer.
// slave is the sequencer side, master is the front-end / observer side.
interface yacht_turn_ctrl_if;
  import yacht_turn_ctrl_pkg::*;

  logic                roll_btn;
  logic                score_btn;
  logic                new_game;
  logic [HOLD_W-1:0]   hold_sw;
  logic [CAT_W-1:0]    cat_sel;
  logic                roll_en;
  logic [HOLD_W-1:0]   hold_mask;
  logic                busy;
  logic [1:0]          rolls_left;
  logic [3:0]          turn_num;
  logic [NUM_CATS-1:0] used_cats;
  logic                score_commit;
  logic [CAT_W-1:0]    score_cat;
  logic                cat_err;
  logic                game_over;

  modport slave (
    input  roll_btn, score_btn, new_game, hold_sw, cat_sel,
    output roll_en, hold_mask, busy, rolls_left, turn_num, used_cats,
           score_commit, score_cat, cat_err, game_over
  );

  modport master (
    output roll_btn, score_btn, new_game, hold_sw, cat_sel,
    input  roll_en, hold_mask, busy, rolls_left, turn_num, used_cats,
           score_commit, score_cat, cat_err, game_over
  );
endinterface

// File: rtl/yacht_turn_ctrl_roll_anim_timer.sv
// Rolling-animation timer: after start, emits ANIM_STEPS tick pulses spaced
// ANIM_DIV cycles apart; done accompanies the final tick.
module roll_anim_timer #(
  parameter int ANIM_DIV   = 5_000_000,
  parameter int ANIM_STEPS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic tick,
  output logic done
);
  localparam int DW = $clog2(ANIM_DIV);
  localparam int SW = (ANIM_STEPS > 1) ? $clog2(ANIM_STEPS) : 1;

  logic          active;
  logic [DW-1:0] cnt;
  logic [SW-1:0] step;

  // tick is registered off cnt==1 so it lands exactly when the divider hits 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      step   <= '0;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (start) begin
        active <= 1'b1;
        cnt    <= DW'(ANIM_DIV - 1);
        step   <= '0;
      end else if (active) begin
        cnt <= (cnt == '0) ? DW'(ANIM_DIV - 1) : cnt - 1'b1;
        if (cnt == DW'(1)) begin
          tick <= 1'b1;
          if (step == SW'(ANIM_STEPS - 1)) begin
            done   <= 1'b1;
            active <= 1'b0;
            step   <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/yacht_turn_ctrl.sv
// Yacht Dice turn sequencer: roll requests -> timed roll_en burst with latched
// hold mask, 3-roll limit, category commit bookkeeping and game-over detection.
module yacht_turn_ctrl
  import yacht_turn_ctrl_pkg::*;
#(
  parameter int ANIM_DIV   = 5_000_000,
  parameter int ANIM_STEPS = 8,
  parameter int MAX_ROLLS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  yacht_turn_ctrl_if.slave  bus
);
  state_t              state, nxt;
  logic                start, roll_ok, score_ok, score_bad;
  logic                tick, done;
  logic [HOLD_W-1:0]   hold_mask;
  logic [1:0]          rolls_left;
  logic [3:0]          turn_num;
  logic [NUM_CATS-1:0] used_cats;
  logic [CAT_W-1:0]    score_cat;
  logic                cat_err;
  logic                clear;

  roll_anim_timer #(.ANIM_DIV(ANIM_DIV), .ANIM_STEPS(ANIM_STEPS)) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .tick  (tick),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    start     = 1'b0;
    roll_ok   = 1'b0;
    score_ok  = 1'b0;
    score_bad = 1'b0;
    case (state)
      S_IDLE: if (bus.roll_btn) begin
        nxt     = S_ROLL;
        start   = 1'b1;
        roll_ok = 1'b1;
      end
      S_ROLL: if (done) nxt = S_DECIDE;
      // Score has priority over a simultaneous roll request.
      S_DECIDE: begin
        if (bus.score_btn) begin
          if (cat_ok(bus.cat_sel, used_cats)) begin
            score_ok = 1'b1;
            nxt      = S_COMMIT;
          end else begin
            score_bad = 1'b1;
          end
        end else if (bus.roll_btn && rolls_left != 2'd0) begin
          nxt     = S_ROLL;
          start   = 1'b1;
          roll_ok = 1'b1;
        end
      end
      S_COMMIT: nxt = (turn_num == 4'(NUM_CATS - 1)) ? S_OVER : S_IDLE;
      S_OVER:   if (bus.new_game) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign clear = reset || (state == S_OVER && bus.new_game);

  always_ff @(posedge clk) begin
    if (clear) begin
      hold_mask  <= '0;
      rolls_left <= 2'(MAX_ROLLS);
      turn_num   <= '0;
      used_cats  <= '0;
      score_cat  <= '0;
      cat_err    <= 1'b0;
    end else begin
      cat_err <= score_bad;
      // First roll of a turn always rerolls every die.
      if (roll_ok) begin
        rolls_left <= rolls_left - 2'd1;
        hold_mask  <= (state == S_IDLE) ? '0 : bus.hold_sw;
      end
      if (score_ok) score_cat <= bus.cat_sel;
      if (state == S_COMMIT) begin
        used_cats[score_cat] <= 1'b1;
        turn_num             <= turn_num + 4'd1;
        rolls_left           <= 2'(MAX_ROLLS);
      end
    end
  end

  assign bus.roll_en      = tick;
  assign bus.hold_mask    = hold_mask;
  assign bus.busy         = (state == S_ROLL);
  assign bus.rolls_left   = rolls_left;
  assign bus.turn_num     = turn_num;
  assign bus.used_cats    = used_cats;
  assign bus.score_commit = (state == S_COMMIT);
  assign bus.score_cat    = score_cat;
  assign bus.cat_err      = cat_err;
  assign bus.game_over    = (state == S_OVER);
endmodule
